axi4lite2apb: RTL and testbench

AXI4LITE2APB -- requirements
Module: axi4lite2apb

---
 rtl/axi4lite2apb.sv | 174 +++++++++++++++++
 tb/tb_axi4lite2apb.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite2apb.sv
// AXI4-Lite slave to APB master bridge.
// One transaction in flight at a time; write/read arbitration alternates when
// both are eligible in the same IDLE cycle. APB outputs come straight from
// registers captured on the grant cycle.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for AW+W or AR; READY strobes raised only here
// S_SETUP  | APB setup phase, PSEL=1 PENABLE=0 for one cycle
// S_ACCESS | APB access phase, held until PREADY=1
// S_WRESP  | BVALID held until BREADY
// S_RRESP  | RVALID held until RREADY

module axi4lite2apb #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            CLK,
    input  logic            RST,

    input  logic            AXIS_AWVALID,
    output logic            AXIS_AWREADY,
    input  logic [AW-1:0]   AXIS_AWADDR,
    input  logic [2:0]      AXIS_AWPROT,

    input  logic            AXIS_WVALID,
    output logic            AXIS_WREADY,
    input  logic [DW-1:0]   AXIS_WDATA,
    input  logic [DW/8-1:0] AXIS_WSTRB,

    output logic            AXIS_BVALID,
    input  logic            AXIS_BREADY,
    output logic [1:0]      AXIS_BRESP,

    input  logic            AXIS_ARVALID,
    output logic            AXIS_ARREADY,
    input  logic [AW-1:0]   AXIS_ARADDR,
    input  logic [2:0]      AXIS_ARPROT,

    output logic            AXIS_RVALID,
    input  logic            AXIS_RREADY,
    output logic [DW-1:0]   AXIS_RDATA,
    output logic [1:0]      AXIS_RRESP,

    output logic            APBM_PSEL,
    output logic            APBM_PENABLE,
    output logic            APBM_PWRITE,
    output logic [AW-1:0]   APBM_PADDR,
    output logic [DW-1:0]   APBM_PWDATA,
    output logic [DW/8-1:0] APBM_PSTRB,
    output logic [2:0]      APBM_PPROT,
    input  logic [DW-1:0]   APBM_PRDATA,
    input  logic            APBM_PREADY,
    input  logic            APBM_PSLVERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_WRESP,
        S_RRESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t     state;
    logic       prefer_wr;
    logic       wr_elig;
    logic       rd_elig;
    logic       in_idle;
    logic       grant_wr;
    logic       grant_rd;
    logic [1:0] slv_resp;

    // Grant decode: a write needs both AW and W; a lone AW or W never stalls a read.
    // Grants are suppressed while RST is high so no handshake is lost to reset.
    always_comb begin
        wr_elig  = AXIS_AWVALID & AXIS_WVALID;
        rd_elig  = AXIS_ARVALID;
        in_idle  = (state == S_IDLE) & ~RST;
        grant_wr = in_idle & wr_elig & (~rd_elig | prefer_wr);
        grant_rd = in_idle & rd_elig & ~grant_wr;
        slv_resp = APBM_PSLVERR ? RESP_SLVERR : RESP_OKAY;
    end

    // READY strobes are combinational so the handshake completes in the grant cycle.
    always_comb begin
        AXIS_AWREADY = grant_wr;
        AXIS_WREADY  = grant_wr;
        AXIS_ARREADY = grant_rd;
    end

    // Main sequencer: arbitration, APB phase control and response registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= S_IDLE;
            prefer_wr    <= 1'b1;
            APBM_PSEL    <= 1'b0;
            APBM_PENABLE <= 1'b0;
            APBM_PWRITE  <= 1'b0;
            APBM_PADDR   <= '0;
            APBM_PWDATA  <= '0;
            APBM_PSTRB   <= '0;
            APBM_PPROT   <= '0;
            AXIS_BVALID  <= 1'b0;
            AXIS_BRESP   <= RESP_OKAY;
            AXIS_RVALID  <= 1'b0;
            AXIS_RDATA   <= '0;
            AXIS_RRESP   <= RESP_OKAY;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_wr) begin
                        APBM_PADDR  <= AXIS_AWADDR;
                        APBM_PPROT  <= AXIS_AWPROT;
                        APBM_PWRITE <= 1'b1;
                        APBM_PWDATA <= AXIS_WDATA;
                        APBM_PSTRB  <= AXIS_WSTRB;
                        APBM_PSEL   <= 1'b1;
                        prefer_wr   <= 1'b0;
                        state       <= S_SETUP;
                    end else if (grant_rd) begin
                        // PWDATA deliberately keeps the last write data on reads.
                        APBM_PADDR  <= AXIS_ARADDR;
                        APBM_PPROT  <= AXIS_ARPROT;
                        APBM_PWRITE <= 1'b0;
                        APBM_PSTRB  <= '0;
                        APBM_PSEL   <= 1'b1;
                        prefer_wr   <= 1'b1;
                        state       <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    APBM_PENABLE <= 1'b1;
                    state        <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (APBM_PREADY) begin
                        APBM_PSEL    <= 1'b0;
                        APBM_PENABLE <= 1'b0;
                        if (APBM_PWRITE) begin
                            AXIS_BRESP  <= slv_resp;
                            AXIS_BVALID <= 1'b1;
                            state       <= S_WRESP;
                        end else begin
                            AXIS_RDATA  <= APBM_PRDATA;
                            AXIS_RRESP  <= slv_resp;
                            AXIS_RVALID <= 1'b1;
                            state       <= S_RRESP;
                        end
                    end
                end
                S_WRESP: begin
                    if (AXIS_BREADY) begin
                        AXIS_BVALID <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                S_RRESP: begin
                    if (AXIS_RREADY) begin
                        AXIS_RVALID <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4lite2apb.sv
// Bench for axi4lite2apb: directed sequences with cycle-level checks, an APB
// slave model with programmable wait states, and queues of expected APB
// transfers and AXI responses that are popped as the DUT produces them.

module tb_axi4lite2apb;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;

    logic        AXIS_AWVALID, AXIS_AWREADY;
    logic [31:0] AXIS_AWADDR;
    logic [2:0]  AXIS_AWPROT;
    logic        AXIS_WVALID, AXIS_WREADY;
    logic [31:0] AXIS_WDATA;
    logic [3:0]  AXIS_WSTRB;
    logic        AXIS_BVALID, AXIS_BREADY;
    logic [1:0]  AXIS_BRESP;
    logic        AXIS_ARVALID, AXIS_ARREADY;
    logic [31:0] AXIS_ARADDR;
    logic [2:0]  AXIS_ARPROT;
    logic        AXIS_RVALID, AXIS_RREADY;
    logic [31:0] AXIS_RDATA;
    logic [1:0]  AXIS_RRESP;
    logic        APBM_PSEL, APBM_PENABLE, APBM_PWRITE;
    logic [31:0] APBM_PADDR, APBM_PWDATA;
    logic [3:0]  APBM_PSTRB;
    logic [2:0]  APBM_PPROT;
    logic [31:0] APBM_PRDATA;
    logic        APBM_PREADY, APBM_PSLVERR;

    always #5 CLK = ~CLK;

    axi4lite2apb #(.AW(32), .DW(32)) dut (
        .CLK(CLK), .RST(RST),
        .AXIS_AWVALID(AXIS_AWVALID), .AXIS_AWREADY(AXIS_AWREADY),
        .AXIS_AWADDR(AXIS_AWADDR), .AXIS_AWPROT(AXIS_AWPROT),
        .AXIS_WVALID(AXIS_WVALID), .AXIS_WREADY(AXIS_WREADY),
        .AXIS_WDATA(AXIS_WDATA), .AXIS_WSTRB(AXIS_WSTRB),
        .AXIS_BVALID(AXIS_BVALID), .AXIS_BREADY(AXIS_BREADY), .AXIS_BRESP(AXIS_BRESP),
        .AXIS_ARVALID(AXIS_ARVALID), .AXIS_ARREADY(AXIS_ARREADY),
        .AXIS_ARADDR(AXIS_ARADDR), .AXIS_ARPROT(AXIS_ARPROT),
        .AXIS_RVALID(AXIS_RVALID), .AXIS_RREADY(AXIS_RREADY),
        .AXIS_RDATA(AXIS_RDATA), .AXIS_RRESP(AXIS_RRESP),
        .APBM_PSEL(APBM_PSEL), .APBM_PENABLE(APBM_PENABLE), .APBM_PWRITE(APBM_PWRITE),
        .APBM_PADDR(APBM_PADDR), .APBM_PWDATA(APBM_PWDATA), .APBM_PSTRB(APBM_PSTRB),
        .APBM_PPROT(APBM_PPROT), .APBM_PRDATA(APBM_PRDATA),
        .APBM_PREADY(APBM_PREADY), .APBM_PSLVERR(APBM_PSLVERR)
    );

    // APB slave model: PREADY rises after ws wait cycles of the access phase.
    int          ws = 0;
    int          acc_cnt = 0;
    logic        slv_err = 1'b0;
    logic [31:0] slv_rdata = '0;

    always @(posedge CLK)
        acc_cnt <= (APBM_PSEL && APBM_PENABLE && !APBM_PREADY) ? acc_cnt + 1 : 0;

    assign APBM_PREADY  = APBM_PSEL && APBM_PENABLE && (acc_cnt == ws);
    assign APBM_PSLVERR = slv_err;
    assign APBM_PRDATA  = slv_rdata;

    int chk_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
    } apb_t;

    typedef struct {
        logic        wr;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } resp_t;

    apb_t        exp_apb[$];
    resp_t       exp_resp[$];
    logic [31:0] mdl_pwdata = '0;

    task automatic push_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
        exp_apb.push_back('{addr: a, wr: 1'b1, wdata: d, strb: s, prot: p});
        exp_resp.push_back('{wr: 1'b1, resp: (slv_err ? 2'b10 : 2'b00), rdata: 32'h0});
        mdl_pwdata = d;
    endtask

    task automatic push_r(input logic [31:0] a, input logic [2:0] p);
        exp_apb.push_back('{addr: a, wr: 1'b0, wdata: mdl_pwdata, strb: 4'h0, prot: p});
        exp_resp.push_back('{wr: 1'b0, resp: (slv_err ? 2'b10 : 2'b00), rdata: slv_rdata});
    endtask

    task automatic drv_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
        AXIS_AWADDR = a; AXIS_AWPROT = p; AXIS_WDATA = d; AXIS_WSTRB = s;
        AXIS_AWVALID = 1'b1; AXIS_WVALID = 1'b1;
    endtask

    task automatic drv_r(input logic [31:0] a, input logic [2:0] p);
        AXIS_ARADDR = a; AXIS_ARPROT = p; AXIS_ARVALID = 1'b1;
    endtask

    // Scoreboard monitor, sampled mid-low-phase after stimulus has settled.
    always @(negedge CLK) begin
        #2;
        if (APBM_PSEL && APBM_PENABLE && APBM_PREADY) begin
            if (exp_apb.size() == 0) chk("sb_apb_underflow", exp_apb.size(), 1);
            else begin
                apb_t e;
                e = exp_apb.pop_front();
                chk("sb_paddr", APBM_PADDR, e.addr);
                chk("sb_pwrite", APBM_PWRITE, e.wr);
                chk("sb_pwdata", APBM_PWDATA, e.wdata);
                chk("sb_pstrb", APBM_PSTRB, e.strb);
                chk("sb_pprot", APBM_PPROT, e.prot);
            end
        end
        if (AXIS_BVALID) chk("bresp_legal", AXIS_BRESP[0], 1'b0);
        if (AXIS_RVALID) chk("rresp_legal", AXIS_RRESP[0], 1'b0);
        if ((AXIS_BVALID && AXIS_BREADY) || (AXIS_RVALID && AXIS_RREADY)) begin
            if (exp_resp.size() == 0) chk("sb_resp_underflow", exp_resp.size(), 1);
            else begin
                resp_t r;
                r = exp_resp.pop_front();
                chk("sb_resp_type", AXIS_BVALID, r.wr);
                if (AXIS_BVALID) chk("sb_bresp", AXIS_BRESP, r.resp);
                else begin
                    chk("sb_rresp", AXIS_RRESP, r.resp);
                    chk("sb_rdata", AXIS_RDATA, r.rdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] ord;
        logic       got, gw, gr, seen, ok;
        int         acc, nw, nr;

        AXIS_AWADDR = '0; AXIS_AWPROT = '0; AXIS_WDATA = '0; AXIS_WSTRB = '0;
        AXIS_ARADDR = '0; AXIS_ARPROT = '0;
        AXIS_AWVALID = 1'b1; AXIS_WVALID = 1'b1; AXIS_ARVALID = 1'b1;
        AXIS_BREADY = 1'b1; AXIS_RREADY = 1'b1;

        // Reset state, with requests pending that must not be granted.
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_awready", AXIS_AWREADY, 0);
        chk("rst_arready", AXIS_ARREADY, 0);
        chk("rst_psel", APBM_PSEL, 0);
        chk("rst_penable", APBM_PENABLE, 0);
        chk("rst_pwrite", APBM_PWRITE, 0);
        chk("rst_paddr", APBM_PADDR, 0);
        chk("rst_pwdata", APBM_PWDATA, 0);
        chk("rst_pstrb", APBM_PSTRB, 0);
        chk("rst_pprot", APBM_PPROT, 0);
        chk("rst_bvalid", AXIS_BVALID, 0);
        chk("rst_rvalid", AXIS_RVALID, 0);
        chk("rst_rdata", AXIS_RDATA, 0);
        chk("rst_bresp", AXIS_BRESP, 0);
        chk("rst_rresp", AXIS_RRESP, 0);
        @(negedge CLK);
        AXIS_AWVALID = 1'b0; AXIS_WVALID = 1'b0; AXIS_ARVALID = 1'b0;
        RST = 1'b0;
        @(negedge CLK);

        // Zero-wait write with cycle-exact latency.
        ws = 0;
        drv_w(32'h100, 32'hDEADBEEF, 4'hF, 3'b000);
        push_w(32'h100, 32'hDEADBEEF, 4'hF, 3'b000);
        #1;
        chk("t1_awready", AXIS_AWREADY, 1);
        chk("t1_wready", AXIS_WREADY, 1);
        chk("t1_arready", AXIS_ARREADY, 0);
        @(negedge CLK);
        AXIS_AWVALID = 1'b0; AXIS_WVALID = 1'b0;
        #1;
        chk("t1_setup_psel", APBM_PSEL, 1);
        chk("t1_setup_penable", APBM_PENABLE, 0);
        chk("t1_setup_awready", AXIS_AWREADY, 0);
        @(negedge CLK); #1;
        chk("t1_acc_psel", APBM_PSEL, 1);
        chk("t1_acc_penable", APBM_PENABLE, 1);
        chk("t1_acc_paddr", APBM_PADDR, 32'h100);
        chk("t1_acc_pwdata", APBM_PWDATA, 32'hDEADBEEF);
        chk("t1_acc_pstrb", APBM_PSTRB, 4'hF);
        chk("t1_acc_pwrite", APBM_PWRITE, 1);
        @(negedge CLK); #1;
        chk("t1_bvalid", AXIS_BVALID, 1);
        chk("t1_bresp", AXIS_BRESP, 2'b00);
        chk("t1_psel_drop", APBM_PSEL, 0);
        @(negedge CLK); #1;
        chk("t1_bvalid_clear", AXIS_BVALID, 0);

        // Read with 3 wait states and a slave error.
        @(negedge CLK);
        ws = 3; slv_err = 1'b1; slv_rdata = 32'h12345678;
        drv_r(32'h200, 3'b010);
        push_r(32'h200, 3'b010);
        #1;
        chk("t2_arready", AXIS_ARREADY, 1);
        @(negedge CLK);
        AXIS_ARVALID = 1'b0;
        acc = 0; got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (APBM_PSEL && APBM_PENABLE) acc++;
            if (AXIS_RVALID) begin
                got = 1'b1;
                chk("t2_rdata", AXIS_RDATA, 32'h12345678);
                chk("t2_rresp", AXIS_RRESP, 2'b10);
                break;
            end
            @(negedge CLK);
        end
        chk("t2_rvalid_seen", got, 1);
        chk("t2_access_cycles", acc, 4);
        @(negedge CLK);
        slv_err = 1'b0;
        #1;
        chk("t2_rvalid_clear", AXIS_RVALID, 0);

        // Simultaneous write/read requests after a reset: W R W R.
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0; mdl_pwdata = '0;
        ws = 1; slv_rdata = 32'hA5A50001;
        push_w(32'h300, 32'h11111111, 4'hF, 3'b001);
        push_r(32'h304, 3'b000);
        push_w(32'h308, 32'h22222222, 4'h3, 3'b000);
        push_r(32'h30C, 3'b100);
        drv_w(32'h300, 32'h11111111, 4'hF, 3'b001);
        drv_r(32'h304, 3'b000);
        ord = '0; nw = 0; nr = 0;
        for (int c = 0; c < 80 && (nw < 2 || nr < 2); c++) begin
            #1;
            gw = AXIS_AWREADY; gr = AXIS_ARREADY;
            if (gw || gr) begin
                chk("t3_exclusive", gw & gr, 0);
                ord = {ord[2:0], gw};
            end
            @(negedge CLK);
            if (gw) begin
                nw++;
                if (nw == 1) drv_w(32'h308, 32'h22222222, 4'h3, 3'b000);
                else begin AXIS_AWVALID = 1'b0; AXIS_WVALID = 1'b0; end
            end
            if (gr) begin
                nr++;
                if (nr == 1) drv_r(32'h30C, 3'b100);
                else AXIS_ARVALID = 1'b0;
            end
        end
        chk("t3_grants", nw + nr, 4);
        chk("t3_order", ord, 4'b1010);
        repeat (8) @(negedge CLK);

        // Lone AWVALID must not be granted nor block a read.
        ws = 0; slv_rdata = 32'h0BADF00D;
        AXIS_AWADDR = 32'h400; AXIS_AWPROT = 3'b000; AXIS_WDATA = 32'hCAFEF00D; AXIS_WSTRB = 4'hC;
        AXIS_AWVALID = 1'b1;
        drv_r(32'h404, 3'b001);
        push_r(32'h404, 3'b001);
        #1;
        chk("t4_arready", AXIS_ARREADY, 1);
        chk("t4_awready", AXIS_AWREADY, 0);
        @(negedge CLK);
        AXIS_ARVALID = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            #1;
            seen |= AXIS_AWREADY;
            @(negedge CLK);
        end
        chk("t4_aw_blocked", seen, 0);
        AXIS_WVALID = 1'b1;
        push_w(32'h400, 32'hCAFEF00D, 4'hC, 3'b000);
        #1;
        chk("t4_aw_after_w", AXIS_AWREADY, 1);
        @(negedge CLK);
        AXIS_AWVALID = 1'b0; AXIS_WVALID = 1'b0;
        repeat (5) @(negedge CLK);

        // Stalled B response blocks a pending read until the handshake.
        AXIS_BREADY = 1'b0;
        drv_w(32'h500, 32'h55AA55AA, 4'hF, 3'b000);
        push_w(32'h500, 32'h55AA55AA, 4'hF, 3'b000);
        #1;
        chk("t5_awready", AXIS_AWREADY, 1);
        @(negedge CLK);
        AXIS_AWVALID = 1'b0; AXIS_WVALID = 1'b0;
        slv_rdata = 32'h00C0FFEE;
        drv_r(32'h504, 3'b000);
        push_r(32'h504, 3'b000);
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (AXIS_BVALID) begin got = 1'b1; break; end
            @(negedge CLK);
        end
        chk("t5_bvalid", got, 1);
        seen = 1'b0; ok = 1'b1;
        repeat (10) begin
            seen |= AXIS_ARREADY;
            ok &= AXIS_BVALID;
            @(negedge CLK); #1;
        end
        chk("t5_ar_blocked", seen, 0);
        chk("t5_bvalid_held", ok, 1);
        AXIS_BREADY = 1'b1;
        #1;
        chk("t5_ar_hs_cycle", AXIS_ARREADY, 0);
        @(negedge CLK); #1;
        chk("t5_ar_grant", AXIS_ARREADY, 1);
        @(negedge CLK);
        AXIS_ARVALID = 1'b0;
        repeat (5) @(negedge CLK);

        // Reset during ACCESS aborts silently; next write completes.
        ws = 6;
        drv_w(32'h600, 32'h66666666, 4'hF, 3'b111);
        #1;
        chk("t6_awready", AXIS_AWREADY, 1);
        @(negedge CLK);
        AXIS_AWVALID = 1'b0; AXIS_WVALID = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (APBM_PSEL && APBM_PENABLE) begin got = 1'b1; break; end
            @(negedge CLK);
        end
        chk("t6_in_access", got, 1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0; mdl_pwdata = '0;
        #1;
        chk("t6_psel", APBM_PSEL, 0);
        chk("t6_penable", APBM_PENABLE, 0);
        chk("t6_pwrite", APBM_PWRITE, 0);
        chk("t6_paddr", APBM_PADDR, 0);
        chk("t6_pwdata", APBM_PWDATA, 0);
        chk("t6_pstrb", APBM_PSTRB, 0);
        chk("t6_pprot", APBM_PPROT, 0);
        seen = 1'b0;
        repeat (8) begin
            seen |= AXIS_BVALID | AXIS_RVALID;
            @(negedge CLK); #1;
        end
        chk("t6_no_resp", seen, 0);
        @(negedge CLK);
        ws = 0;
        drv_w(32'h700, 32'h77777777, 4'h5, 3'b010);
        push_w(32'h700, 32'h77777777, 4'h5, 3'b010);
        #1;
        chk("t6_next_awready", AXIS_AWREADY, 1);
        @(negedge CLK);
        AXIS_AWVALID = 1'b0; AXIS_WVALID = 1'b0;
        repeat (6) @(negedge CLK);
        #3;

        chk("sb_apb_empty", exp_apb.size(), 0);
        chk("sb_resp_empty", exp_resp.size(), 0);
        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule
